ifelse_flag_monitor: RTL and testbench

Downstream consumer of the if/else priority decoder's outputs (b, c, 2-bit d).
- Samples the decoded flags over fixed windows of WINDOW cycles.
- Per window it counts rising edges of b, counts cycles with c high, and captures the last d code.
- Each window's summary is presented on a valid/ready report port to the next stage (status logger / bus interface).

---
 rtl/ifelse_flag_monitor.sv | 181 ++++++++++++++++++
 tb/tb_ifelse_flag_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifelse_flag_monitor.sv
// ifelse_flag_monitor
// Windowed statistics on the if/else priority decoder outputs. Over each
// WINDOW-cycle window it counts rising edges of b, counts cycles with c high
// and captures the last d code. Each window summary is offered on a
// valid/ready report port and held stable until it is accepted.
// Optional build macro: IFELSE_FLAG_MONITOR_OVF_EN adds the rpt_ovf output,
// a sticky per-window flag raised when a saturated counter sees another
// increment.
module ifelse_flag_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16,
    parameter int WIN_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             b_in,
    input  logic             c_in,
    input  logic [1:0]       d_in,
    input  logic             enable,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_b_rise,
    output logic [CNT_W-1:0] rpt_c_high,
    output logic [1:0]       rpt_d_last,
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
    output logic             rpt_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
    logic             b_prev_q;
    logic [CNT_W-1:0] rpt_b_q, rpt_b_d;
    logic [CNT_W-1:0] rpt_c_q, rpt_c_d;
    logic [1:0]       rpt_d_q, rpt_d_d;
    logic             rise;
    logic             win_end;
    logic             accum_run;
    logic [CNT_W-1:0] b_inc;
    logic [CNT_W-1:0] c_inc;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
    logic             ovf_q, ovf_d;
    logic             rpt_ovf_q, rpt_ovf_d;
    logic             ovf_hit;
`endif

    // Increment by one unless already at the all-ones ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic             inc);
        logic [CNT_W-1:0] r;
        r = v;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign rise      = b_in & ~b_prev_q;
    assign win_end   = (win_cnt_q == WIN_LAST);
    // Samples only count in ACCUM while enable stays high; a low enable aborts.
    assign accum_run = (state_q == ACCUM) && enable;
    assign b_inc     = sat_inc(b_cnt_q, rise);
    assign c_inc     = sat_inc(c_cnt_q, c_in);
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
    assign ovf_hit   = (rise && (b_cnt_q == CNT_MAX)) || (c_in && (c_cnt_q == CNT_MAX));
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start on enable, abort on enable drop, hold until handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable)      state_d = IDLE;
                else if (win_end) state_d = HOLD;
            end
            HOLD: begin
                if (rpt_ready) state_d = enable ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter and report next values; counters fall back to zero outside a running window.
    always_comb begin
        win_cnt_d = '0;
        b_cnt_d   = '0;
        c_cnt_d   = '0;
        rpt_b_d   = rpt_b_q;
        rpt_c_d   = rpt_c_q;
        rpt_d_d   = rpt_d_q;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        ovf_d     = 1'b0;
        rpt_ovf_d = rpt_ovf_q;
`endif
        if (accum_run) begin
            if (win_end) begin
                // Final cycle's samples are folded straight into the report.
                rpt_b_d   = b_inc;
                rpt_c_d   = c_inc;
                rpt_d_d   = d_in;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
                rpt_ovf_d = ovf_q | ovf_hit;
`endif
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                b_cnt_d   = b_inc;
                c_cnt_d   = c_inc;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
                ovf_d     = ovf_q | ovf_hit;
`endif
            end
        end
    end

    // Datapath registers; b_prev tracks b_in in every state so edges spanning a window start are seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt_q <= '0;
            b_cnt_q   <= '0;
            c_cnt_q   <= '0;
            b_prev_q  <= 1'b0;
            rpt_b_q   <= '0;
            rpt_c_q   <= '0;
            rpt_d_q   <= '0;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
            ovf_q     <= 1'b0;
            rpt_ovf_q <= 1'b0;
`endif
        end else begin
            win_cnt_q <= win_cnt_d;
            b_cnt_q   <= b_cnt_d;
            c_cnt_q   <= c_cnt_d;
            b_prev_q  <= b_in;
            rpt_b_q   <= rpt_b_d;
            rpt_c_q   <= rpt_c_d;
            rpt_d_q   <= rpt_d_d;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
            ovf_q     <= ovf_d;
            rpt_ovf_q <= rpt_ovf_d;
`endif
        end
    end

    // Outputs decoded from the registered state; HOLD is exactly the report-valid state.
    always_comb begin
        rpt_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    assign rpt_b_rise = rpt_b_q;
    assign rpt_c_high = rpt_c_q;
    assign rpt_d_last = rpt_d_q;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
    assign rpt_ovf    = rpt_ovf_q;
`endif

endmodule

// File: tb/tb_ifelse_flag_monitor.sv
// Testbench for ifelse_flag_monitor: two instances (8-bit and 3-bit counters)
// share one stimulus stream; expected window reports are computed from the
// stimulus, queued at the last window cycle and compared when reported.
`timescale 1ns/1ps
module tb_ifelse_flag_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic       b_in, c_in, enable, rpt_ready;
    logic [1:0] d_in;

    logic       rpt_valid, busy;
    logic [7:0] rpt_b_rise, rpt_c_high;
    logic [1:0] rpt_d_last;
    logic       rpt_valid_s, busy_s;
    logic [2:0] rpt_b_rise_s, rpt_c_high_s;
    logic [1:0] rpt_d_last_s;
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
    logic       rpt_ovf, rpt_ovf_s;
`endif

    always #5 clock = ~clock;

    ifelse_flag_monitor #(.CNT_W(8), .WINDOW(16), .WIN_W(8)) dut (
        .clock(clock), .reset(reset), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .enable(enable), .rpt_ready(rpt_ready), .rpt_valid(rpt_valid),
        .rpt_b_rise(rpt_b_rise), .rpt_c_high(rpt_c_high), .rpt_d_last(rpt_d_last),
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        .rpt_ovf(rpt_ovf),
`endif
        .busy(busy)
    );

    ifelse_flag_monitor #(.CNT_W(3), .WINDOW(16), .WIN_W(8)) dut_s (
        .clock(clock), .reset(reset), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .enable(enable), .rpt_ready(rpt_ready), .rpt_valid(rpt_valid_s),
        .rpt_b_rise(rpt_b_rise_s), .rpt_c_high(rpt_c_high_s), .rpt_d_last(rpt_d_last_s),
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        .rpt_ovf(rpt_ovf_s),
`endif
        .busy(busy_s)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] c;
        logic [2:0] bs;
        logic [2:0] cs;
        logic [1:0] d;
        logic       ovf;
        logic       ovfs;
    } rpt_t;

    rpt_t       exp_q[$];
    rpt_t       cur;
    int         checks;
    int         errors;
    logic       tog;
    logic       m_bprev;
    logic [7:0] m_b, m_c;
    logic [2:0] m_bs, m_cs;
    logic [1:0] m_d;
    logic       m_ovf, m_ovfs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs and return just after the sampling edge.
    task automatic drive(input logic b, input logic c, input logic [1:0] d,
                         input logic en, input logic rdy, input logic rst);
        b_in = b; c_in = c; d_in = d; enable = en; rpt_ready = rdy; reset = rst;
        @(posedge clock);
        #1;
        m_bprev = rst ? 1'b0 : b;
        tog = ~tog;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(rpt_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_b_rise"}, 32'(rpt_b_rise), 32'd0);
        chk({tag, "_c_high"}, 32'(rpt_c_high), 32'd0);
        chk({tag, "_d_last"}, 32'(rpt_d_last), 32'd0);
        chk({tag, "_valid_s"}, 32'(rpt_valid_s), 32'd0);
        chk({tag, "_busy_s"}, 32'(busy_s), 32'd0);
        chk({tag, "_b_rise_s"}, 32'(rpt_b_rise_s), 32'd0);
        chk({tag, "_c_high_s"}, 32'(rpt_c_high_s), 32'd0);
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        chk({tag, "_ovf"}, 32'(rpt_ovf), 32'd0);
        chk({tag, "_ovf_s"}, 32'(rpt_ovf_s), 32'd0);
`endif
    endtask

    task automatic hold_check(input string tag);
        chk({tag, "_valid"}, 32'(rpt_valid), 32'd1);
        chk({tag, "_valid_s"}, 32'(rpt_valid_s), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_b_rise"}, 32'(rpt_b_rise), 32'(cur.b));
        chk({tag, "_c_high"}, 32'(rpt_c_high), 32'(cur.c));
        chk({tag, "_d_last"}, 32'(rpt_d_last), 32'(cur.d));
        chk({tag, "_b_rise_s"}, 32'(rpt_b_rise_s), 32'(cur.bs));
        chk({tag, "_c_high_s"}, 32'(rpt_c_high_s), 32'(cur.cs));
        chk({tag, "_d_last_s"}, 32'(rpt_d_last_s), 32'(cur.d));
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        chk({tag, "_ovf"}, 32'(rpt_ovf), 32'(cur.ovf));
        chk({tag, "_ovf_s"}, 32'(rpt_ovf_s), 32'(cur.ovfs));
`endif
    endtask

    task automatic check_report(input string tag);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            hold_check(tag);
        end
    endtask

    // One counted ACCUM cycle: update the expected counts, drive, then check timing.
    task automatic accum_step(input logic b, input logic c, input logic [1:0] d,
                              input logic rdy, input bit last);
        rpt_t e;
        logic rise;
        rise = b & ~m_bprev;
        if (rise) begin
            if (m_b == 8'hFF) m_ovf = 1'b1; else m_b = m_b + 8'd1;
            if (m_bs == 3'h7) m_ovfs = 1'b1; else m_bs = m_bs + 3'd1;
        end
        if (c) begin
            if (m_c == 8'hFF) m_ovf = 1'b1; else m_c = m_c + 8'd1;
            if (m_cs == 3'h7) m_ovfs = 1'b1; else m_cs = m_cs + 3'd1;
        end
        m_d = d;
        if (last) begin
            e.b = m_b; e.c = m_c; e.bs = m_bs; e.cs = m_cs;
            e.d = m_d; e.ovf = m_ovf; e.ovfs = m_ovfs;
            exp_q.push_back(e);
        end
        drive(b, c, d, 1'b1, rdy, 1'b0);
        if (!last) begin
            chk("accum_valid_low", 32'(rpt_valid), 32'd0);
            chk("accum_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic model_clear();
        m_b = '0; m_c = '0; m_bs = '0; m_cs = '0; m_d = '0; m_ovf = 1'b0; m_ovfs = 1'b0;
    endtask

    // Full 16-cycle window with a selectable input pattern.
    task automatic run_window(input int mode, input logic rdy);
        logic       b, c;
        logic [1:0] d;
        model_clear();
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: begin b = (i % 2 == 0); c = (i < 5); d = (i == 15) ? 2'd3 : 2'd1; end
                1: begin b = tog; c = i[0]; d = 2'(i); end
                2: begin b = (i % 2 == 0); c = 1'b1; d = 2'd2; end
                3: begin b = 1'b0; c = 1'b0; d = 2'd0; end
                default: begin b = 1'($urandom); c = 1'($urandom); d = 2'($urandom); end
            endcase
            accum_step(b, c, d, rdy, i == 15);
        end
    endtask

    initial begin
        checks = 0; errors = 0; tog = 1'b0; m_bprev = 1'b0;
        model_clear();
        b_in = 0; c_in = 0; d_in = 0; enable = 0; rpt_ready = 0; reset = 1;

        repeat (3) drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check_idle("reset");
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        check_idle("idle");

        // Defaults: single window, report for exactly one cycle.
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("t1_busy_start", 32'(busy), 32'd1);
        run_window(0, 1'b1);
        check_report("t1");
        chk("t1_b_rise_8", 32'(rpt_b_rise), 32'd8);
        chk("t1_c_high_5", 32'(rpt_c_high), 32'd5);
        chk("t1_d_last_3", 32'(rpt_d_last), 32'd3);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_one_cycle", 32'(rpt_valid), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_fields_kept", 32'(rpt_b_rise), 32'd8);

        // Backpressure: ten stalled cycles with b toggling.
        drive(tog, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_window(1, 1'b0);
        check_report("t2a");
        for (int k = 0; k < 10; k++) begin
            drive(tog, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
            hold_check("t2_hold");
        end
        drive(tog, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
        chk("t2_hs_valid", 32'(rpt_valid), 32'd0);
        chk("t2_hs_busy", 32'(busy), 32'd1);
        run_window(1, 1'b1);
        check_report("t2b");
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // Saturation on the 3-bit instance, then a quiet window back to back.
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_window(2, 1'b1);
        check_report("t3a");
        chk("t3_c_high_s_7", 32'(rpt_c_high_s), 32'd7);
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        chk("t3_ovf_s_set", 32'(rpt_ovf_s), 32'd1);
`endif
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_window(3, 1'b1);
        check_report("t3b");
`ifdef IFELSE_FLAG_MONITOR_OVF_EN
        chk("t3_ovf_s_clear", 32'(rpt_ovf_s), 32'd0);
`endif
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // Abort in the 8th ACCUM cycle, then a fresh window.
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        model_clear();
        for (int i = 0; i < 7; i++) accum_step(tog, 1'b1, 2'd1, 1'b1, 1'b0);
        drive(tog, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        chk("t4_abort_valid", 32'(rpt_valid), 32'd0);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(tog, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
            chk("t4_idle_valid", 32'(rpt_valid), 32'd0);
        end
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        run_window(0, 1'b1);
        check_report("t4");
        chk("t4_fresh_b_rise", 32'(rpt_b_rise), 32'd8);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // Reset while a report is pending.
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        run_window(2, 1'b0);
        check_report("t5");
        drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        hold_check("t5_hold");
        drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        check_idle("t5_reset");
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Streaming with random inputs, enable and ready held high.
        drive(1'($urandom), 1'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b0);
        for (int w = 0; w < 4; w++) begin
            run_window(4, 1'b1);
            check_report("t6");
            drive(1'($urandom), 1'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b0);
            chk("t6_hs_valid", 32'(rpt_valid), 32'd0);
            chk("t6_hs_busy", 32'(busy), 32'd1);
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("t6_end_busy", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
